// File: rtl/vanilla_sb_stall_attributor_pkg.sv
// Cause classes and dump geometry for the stall attributor.
// VANILLA_SB_STALL_EPISODE_EN adds two episode words (count, max length) to the dump.
package vanilla_sb_stall_attributor_pkg;

    // Lower value wins when several classes hit in the same cycle.
    typedef enum logic [3:0] {
        CauseIntDram    = 4'd0,
        CauseFpDram     = 4'd1,
        CauseIntGlobal  = 4'd2,
        CauseFpGlobal   = 4'd3,
        CauseIntGroup   = 4'd4,
        CauseFpGroup    = 4'd5,
        CauseIdiv       = 4'd6,
        CauseFdivFsqrt  = 4'd7,
        CauseOther      = 4'd8,
        CauseEpisodeCnt = 4'd9,
        CauseEpisodeMax = 4'd10
    } stall_cause_e;

    localparam int unsigned num_cause_gp = 9;

`ifdef VANILLA_SB_STALL_EPISODE_EN
    localparam int unsigned num_dump_words_gp = 11;
`else
    localparam int unsigned num_dump_words_gp = 9;
`endif

    localparam int unsigned dump_idx_width_gp = 4;
    localparam logic [dump_idx_width_gp-1:0] last_dump_idx_gp =
        dump_idx_width_gp'(num_dump_words_gp - 1);

endpackage

// File: rtl/vanilla_scoreboard_tracker_pkg.sv
// Scoreboard entry types shared between the scoreboard tracker and its consumers.
// Each register slot reports which kind of long-latency producer it is waiting on.
package vanilla_scoreboard_tracker_pkg;

    localparam int unsigned RV32_reg_els_gp = 32;

    typedef struct packed {
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic idiv;
    } vanilla_isb_info_s;

    typedef struct packed {
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic fdiv_fsqrt;
    } vanilla_fsb_info_s;

endpackage

// File: rtl/vanilla_sb_cause_encoder.sv
// Combinational cause encoder: masks plus scoreboards -> one-hot stall cause,
// lowest class index wins, CauseOther when no class hits.
module vanilla_sb_cause_encoder
    import vanilla_scoreboard_tracker_pkg::*;
    import vanilla_sb_stall_attributor_pkg::*;
#(
    parameter int unsigned reg_els_p = RV32_reg_els_gp
) (
    input  logic                             int_dep_mask_i,
    input  logic [reg_els_p-1:0]             float_dep_mask_i,
    input  vanilla_isb_info_s [reg_els_p-1:0] int_sb_i,
    input  vanilla_fsb_info_s [reg_els_p-1:0] float_sb_i,
    input  logic [reg_els_p-1:0]             int_dep_mask_full_i,
    output logic [num_cause_gp-1:0]          cause_oh_o
);

    logic [num_cause_gp-1:0] w_hit;
    logic [num_cause_gp-1:0] w_low;

    // OR-reduce per-register producer kinds into raw class hits; x0 never carries a dependency
    always_comb begin
        w_hit = '0;
        for (int r = 0; r < int'(reg_els_p); r++) begin
            if (r != 0 && int_dep_mask_full_i[r]) begin
                w_hit[CauseIntDram]   |= int_sb_i[r].remote_dram_load;
                w_hit[CauseIntGlobal] |= int_sb_i[r].remote_global_load;
                w_hit[CauseIntGroup]  |= int_sb_i[r].remote_group_load;
                w_hit[CauseIdiv]      |= int_sb_i[r].idiv;
            end
            if (float_dep_mask_i[r]) begin
                w_hit[CauseFpDram]    |= float_sb_i[r].remote_dram_load;
                w_hit[CauseFpGlobal]  |= float_sb_i[r].remote_global_load;
                w_hit[CauseFpGroup]   |= float_sb_i[r].remote_group_load;
                w_hit[CauseFdivFsqrt] |= float_sb_i[r].fdiv_fsqrt;
            end
        end
        // bit 0 of the int mask is the same x0 slot; folded in so it is read but never hits
        w_hit[CauseOther] = 1'b0 & int_dep_mask_i;
    end

    // Keep only the lowest set hit; fall back to CauseOther
    always_comb begin
        w_low      = w_hit & (~w_hit + num_cause_gp'(1));
        cause_oh_o = w_low;
        if (w_hit == '0) begin
            cause_oh_o[CauseOther] = 1'b1;
        end
    end

endmodule

// File: rtl/vanilla_sb_stall_attributor.sv
// Attributes each ID dependency-stall cycle to one cause class and keeps saturating
// per-class counters, drained one word per beat through a valid/yumi dump port.
// VANILLA_SB_STALL_EPISODE_EN adds episode count / max episode length (dump words 9, 10).
module vanilla_sb_stall_attributor
    import vanilla_scoreboard_tracker_pkg::*;
    import vanilla_sb_stall_attributor_pkg::*;
#(
    parameter int unsigned counter_width_p = 32,
    localparam int unsigned reg_els_lp = RV32_reg_els_gp
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic                              stall_depend_i,
    input  logic                              stall_all_i,
    input  logic                              flush_i,
    input  logic [reg_els_lp-1:0]             int_dep_mask_i,
    input  logic [reg_els_lp-1:0]             float_dep_mask_i,
    input  vanilla_isb_info_s [reg_els_lp-1:0] int_sb_i,
    input  vanilla_fsb_info_s [reg_els_lp-1:0] float_sb_i,
    input  logic                              clear_on_dump_i,
    input  logic                              dump_req_i,
    output logic                              dump_busy_o,
    output logic                              dump_v_o,
    output logic [dump_idx_width_gp-1:0]      dump_idx_o,
    output logic [counter_width_p-1:0]        dump_data_o,
    input  logic                              dump_yumi_i
);

    typedef enum logic [0:0] {StIdle, StDump} state_e;

    state_e                         r_state, w_state_d;
    logic [dump_idx_width_gp-1:0]   r_idx, w_idx_d;
    logic [counter_width_p-1:0]     r_cnt    [num_cause_gp];
    logic [counter_width_p-1:0]     w_cnt_d  [num_cause_gp];
    logic [counter_width_p-1:0]     r_shadow [num_dump_words_gp];
    logic [counter_width_p-1:0]     w_snap   [num_dump_words_gp];
    logic [num_cause_gp-1:0]        w_cause_oh;
    logic                           w_counted;
    logic                           w_accept;
    logic                           w_clear;

    function automatic logic [counter_width_p-1:0] sat_inc(
        input logic [counter_width_p-1:0] v,
        input logic                       en
    );
        return (en && (v != '1)) ? v + counter_width_p'(1) : v;
    endfunction

    vanilla_sb_cause_encoder #(
        .reg_els_p (reg_els_lp)
    ) u_encoder (
        .int_dep_mask_i      (int_dep_mask_i[0]),
        .float_dep_mask_i    (float_dep_mask_i),
        .int_sb_i            (int_sb_i),
        .float_sb_i          (float_sb_i),
        .int_dep_mask_full_i (int_dep_mask_i),
        .cause_oh_o          (w_cause_oh)
    );

    assign w_counted = stall_depend_i & ~stall_all_i & ~flush_i;
    assign w_clear   = w_accept & clear_on_dump_i;

    // Dump FSM: accept a request only in idle, walk indices on each yumi
    always_comb begin
        w_state_d = r_state;
        w_idx_d   = r_idx;
        w_accept  = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (dump_req_i) begin
                    w_accept  = 1'b1;
                    w_state_d = StDump;
                    w_idx_d   = '0;
                end
            end
            StDump: begin
                if (dump_yumi_i) begin
                    if (r_idx == last_dump_idx_gp) begin
                        w_state_d = StIdle;
                        w_idx_d   = '0;
                    end else begin
                        w_idx_d = r_idx + dump_idx_width_gp'(1);
                    end
                end
            end
            default: begin
                w_state_d = StIdle;
                w_idx_d   = '0;
            end
        endcase
    end

    // Live class counters; a clear restarts from zero but still takes this cycle's hit
    always_comb begin
        for (int k = 0; k < int'(num_cause_gp); k++) begin
            w_cnt_d[k] = sat_inc(w_clear ? '0 : r_cnt[k], w_counted & w_cause_oh[k]);
        end
    end

`ifdef VANILLA_SB_STALL_EPISODE_EN
    logic                       r_ep_active, w_ep_active_d;
    logic [counter_width_p-1:0] r_ep_len, w_ep_len_d;
    logic [counter_width_p-1:0] r_ep_cnt, w_ep_cnt_d;
    logic [counter_width_p-1:0] r_ep_max, w_ep_max_d;

    // Episode tracking: stall_all pauses a run, any other uncounted cycle (or flush) ends it
    always_comb begin
        w_ep_active_d = r_ep_active;
        w_ep_len_d    = r_ep_len;
        w_ep_cnt_d    = w_clear ? '0 : r_ep_cnt;
        w_ep_max_d    = w_clear ? '0 : r_ep_max;
        if (w_counted) begin
            w_ep_active_d = 1'b1;
            w_ep_len_d    = sat_inc(r_ep_len, 1'b1);
        end else if (stall_all_i && !flush_i) begin
            w_ep_active_d = r_ep_active;
        end else if (r_ep_active) begin
            w_ep_cnt_d    = sat_inc(w_ep_cnt_d, 1'b1);
            if (r_ep_len > w_ep_max_d) begin
                w_ep_max_d = r_ep_len;
            end
            w_ep_active_d = 1'b0;
            w_ep_len_d    = '0;
        end
    end

    // Episode state registers
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_ep_active <= 1'b0;
            r_ep_len    <= '0;
            r_ep_cnt    <= '0;
            r_ep_max    <= '0;
        end else begin
            r_ep_active <= w_ep_active_d;
            r_ep_len    <= w_ep_len_d;
            r_ep_cnt    <= w_ep_cnt_d;
            r_ep_max    <= w_ep_max_d;
        end
    end
`endif

    // Values captured into the shadow on accept (pre-increment state)
    always_comb begin
        for (int k = 0; k < int'(num_cause_gp); k++) begin
            w_snap[k] = r_cnt[k];
        end
`ifdef VANILLA_SB_STALL_EPISODE_EN
        w_snap[CauseEpisodeCnt] = r_ep_cnt;
        w_snap[CauseEpisodeMax] = r_ep_max;
`endif
    end

    // FSM state and dump index
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= StIdle;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_d;
            r_idx   <= w_idx_d;
        end
    end

    // Live counters
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < int'(num_cause_gp); k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(num_cause_gp); k++) begin
                r_cnt[k] <= w_cnt_d[k];
            end
        end
    end

    // Shadow array, only written on accept so a held word stays stable
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < int'(num_dump_words_gp); k++) begin
                r_shadow[k] <= '0;
            end
        end else if (w_accept) begin
            for (int k = 0; k < int'(num_dump_words_gp); k++) begin
                r_shadow[k] <= w_snap[k];
            end
        end
    end

    // Dump port outputs; data forced to zero outside a dump
    always_comb begin
        dump_v_o    = (r_state == StDump);
        dump_busy_o = (r_state == StDump);
        dump_idx_o  = r_idx;
        dump_data_o = '0;
        if (r_state == StDump && r_idx <= last_dump_idx_gp) begin
            dump_data_o = r_shadow[r_idx];
        end
    end

endmodule
